// File: rtl/debug_sequencer.sv
// Debug-host command sequencer: owns the decode-stage halt line and the register-file
// debug read port, single-steps the pipeline and streams all registers out MSB-first.
module debug_sequencer #(
    parameter int N_REGS  = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    input  logic [7:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic               i_prog_halt,
    output logic               o_halt,
    output logic [NB_ADDR-1:0] o_r_addr,
    input  logic [NB_DATA-1:0] i_r_data,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_cmd_err
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    localparam logic [7:0] CMD_HALT = 8'h68;
    localparam logic [7:0] CMD_RUN  = 8'h72;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    localparam logic [NB_IDX-1:0]  LAST_IDX = NB_IDX'(NB_BYTES - 1);
    localparam logic [NB_ADDR-1:0] LAST_REG = NB_ADDR'(N_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        DUMP_WAIT,
        LOAD,
        SEND
    } state_t;

    state_t               state, state_n;
    logic                 user_halt, user_halt_n;
    logic                 prog_halt, prog_halt_n;
    logic                 dump_halt, dump_halt_n;
    logic                 halt_q, halt_n;
    logic [NB_ADDR-1:0]   reg_cnt, reg_cnt_n;
    logic [NB_DATA-1:0]   shift_reg, shift_reg_n;
    logic [NB_IDX-1:0]    byte_idx, byte_idx_n;
    logic                 done_q, done_n;
    logic                 err_q, err_n;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            user_halt <= 1'b0;
            prog_halt <= 1'b0;
            dump_halt <= 1'b0;
            halt_q    <= 1'b0;
            reg_cnt   <= '0;
            shift_reg <= '0;
            byte_idx  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            user_halt <= user_halt_n;
            prog_halt <= prog_halt_n;
            dump_halt <= dump_halt_n;
            halt_q    <= halt_n;
            reg_cnt   <= reg_cnt_n;
            shift_reg <= shift_reg_n;
            byte_idx  <= byte_idx_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    // prog_halt is sticky and sampled in every state, including mid-step and mid-dump.
    always_comb begin
        state_n     = state;
        user_halt_n = user_halt;
        prog_halt_n = prog_halt | i_prog_halt;
        dump_halt_n = dump_halt;
        reg_cnt_n   = reg_cnt;
        shift_reg_n = shift_reg;
        byte_idx_n  = byte_idx;
        done_n      = 1'b0;
        err_n       = 1'b0;

        case (state)
            IDLE: begin
                if (i_cmd_valid) begin
                    case (i_cmd)
                        CMD_HALT: user_halt_n = 1'b1;
                        CMD_RUN:  user_halt_n = 1'b0;
                        CMD_STEP: begin
                            if (user_halt && !prog_halt) begin
                                state_n = STEP;
                            end
                        end
                        CMD_DUMP: begin
                            state_n     = DUMP_WAIT;
                            dump_halt_n = 1'b1;
                            reg_cnt_n   = '0;
                        end
                        default:  err_n = 1'b1;
                    endcase
                end
            end
            STEP:      state_n = IDLE;
            DUMP_WAIT: state_n = LOAD;
            LOAD: begin
                shift_reg_n = i_r_data;
                byte_idx_n  = '0;
                state_n     = SEND;
            end
            SEND: begin
                if (i_tx_ready) begin
                    shift_reg_n = shift_reg << 8;
                    byte_idx_n  = byte_idx + NB_IDX'(1);
                    if (byte_idx == LAST_IDX) begin
                        if (reg_cnt == LAST_REG) begin
                            state_n     = IDLE;
                            dump_halt_n = 1'b0;
                            done_n      = 1'b1;
                        end else begin
                            reg_cnt_n = reg_cnt + NB_ADDR'(1);
                            state_n   = LOAD;
                        end
                    end
                end
            end
            default:   state_n = IDLE;
        endcase

        // Releasing the freeze for exactly the STEP cycle lets the pipeline advance one clock.
        halt_n = (state == IDLE && state_n == STEP) ? 1'b0
                                                    : (user_halt_n | prog_halt_n | dump_halt_n);
    end

    assign o_halt      = halt_q;
    assign o_r_addr    = reg_cnt;
    assign o_tx_data   = shift_reg[NB_DATA-1 -: 8];
    assign o_tx_valid  = (state == SEND);
    assign o_cmd_ready = (state == IDLE);
    assign o_busy      = (state != IDLE);
    assign o_done      = done_q;
    assign o_cmd_err   = err_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Randomized scoreboard bench for debug_sequencer: a behavioural halt/dump model feeds
// expected bytes, done and error pulses into queues that a negedge monitor drains.
module tb_debug_sequencer;

    localparam int N_REGS  = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_DATA = 32;

    logic               i_clk       = 1'b0;
    logic               i_reset     = 1'b1;
    logic               i_cmd_valid = 1'b0;
    logic [7:0]         i_cmd       = 8'h00;
    logic               o_cmd_ready;
    logic               i_prog_halt = 1'b0;
    logic               o_halt;
    logic [NB_ADDR-1:0] o_r_addr;
    logic [NB_DATA-1:0] i_r_data;
    logic [7:0]         o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready  = 1'b1;
    logic               o_busy;
    logic               o_done;
    logic               o_cmd_err;

    logic [NB_DATA-1:0] regfile [N_REGS];

    debug_sequencer #(.N_REGS(N_REGS), .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid),
        .i_cmd(i_cmd),
        .o_cmd_ready(o_cmd_ready),
        .i_prog_halt(i_prog_halt),
        .o_halt(o_halt),
        .o_r_addr(o_r_addr),
        .i_r_data(i_r_data),
        .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_cmd_err(o_cmd_err)
    );

    assign i_r_data = regfile[o_r_addr];

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // 0: always ready, 1: ready roughly one cycle in three
    int ready_mode = 0;
    always @(posedge i_clk) begin
        #1;
        if (ready_mode == 0) i_tx_ready = 1'b1;
        else                 i_tx_ready = ($urandom_range(2) == 0);
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] byte_q [$];
    int         done_q [$];
    int         err_q  [$];
    int         bytes_seen = 0;

    logic       m_user = 1'b0;
    logic       m_prog = 1'b0;
    int         accept_cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: drains the scoreboard whenever the DUT presents a byte, done or error pulse.
    logic       hold_pending = 1'b0;
    logic [7:0] hold_data    = 8'h00;
    always @(negedge i_clk) begin
        if (i_reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("tx_hold_valid", 32'(o_tx_valid), 32'd1);
                checkOutput("tx_hold_data", 32'(o_tx_data), 32'(hold_data));
            end
            hold_pending = o_tx_valid && !i_tx_ready;
            hold_data    = o_tx_data;
            if (o_tx_valid && i_tx_ready) begin
                bytes_seen++;
                if (byte_q.size() == 0) begin
                    checkOutput("tx_unexpected_byte", 32'(o_tx_data), 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = byte_q.pop_front();
                    checkOutput("tx_byte", 32'(o_tx_data), 32'(e));
                end
            end
            if (o_done) begin
                if (done_q.size() == 0) begin
                    checkOutput("done_unexpected", 32'd1, 32'd0);
                end else begin
                    int e;
                    e = done_q.pop_front();
                    if (e >= 0) checkOutput("done_cycle", 32'(cyc), 32'(e));
                end
            end
            if (o_cmd_err) begin
                if (err_q.size() == 0) begin
                    checkOutput("cmd_err_unexpected", 32'd1, 32'd0);
                end else begin
                    int e;
                    e = err_q.pop_front();
                    checkOutput("cmd_err_cycle", 32'(cyc), 32'(e));
                end
            end
        end
    end

    function automatic logic isKnown(input logic [7:0] c);
        return (c == 8'h68) || (c == 8'h72) || (c == 8'h73) || (c == 8'h64);
    endfunction

    // Issue one command; returns at accept edge + 1 with accept_cyc naming the next cycle.
    task automatic applyStimulus(input logic [7:0] c);
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        @(negedge i_clk);
        checkOutput("cmd_ready_before_accept", 32'(o_cmd_ready), 32'd1);
        @(posedge i_clk);
        #1;
        accept_cyc  = cyc;
        i_cmd_valid = 1'b0;
        if (c == 8'h68) m_user = 1'b1;
        if (c == 8'h72) m_user = 1'b0;
        if (!isKnown(c)) err_q.push_back(accept_cyc);
    endtask

    task automatic pushDump(input int done_cycle);
        for (int r = 0; r < N_REGS; r++) begin
            for (int b = NB_DATA / 8 - 1; b >= 0; b--) begin
                byte_q.push_back(8'((regfile[r] >> (8 * b)) & 32'hFF));
            end
        end
        done_q.push_back(done_cycle);
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_done && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput(name, 32'(o_done), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_halt"},      32'(o_halt),      32'd0);
        checkOutput({tag, "_r_addr"},    32'(o_r_addr),    32'd0);
        checkOutput({tag, "_tx_data"},   32'(o_tx_data),   32'd0);
        checkOutput({tag, "_tx_valid"},  32'(o_tx_valid),  32'd0);
        checkOutput({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
        checkOutput({tag, "_busy"},      32'(o_busy),      32'd0);
        checkOutput({tag, "_done"},      32'(o_done),      32'd0);
        checkOutput({tag, "_cmd_err"},   32'(o_cmd_err),   32'd0);
    endtask

    initial begin
        for (int r = 0; r < N_REGS; r++) regfile[r] = 32'h1111_0000 + 32'(r);

        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        checkResetValues("reset");

        $display("[TB] halt / run");
        applyStimulus(8'h68);
        @(negedge i_clk);
        checkOutput("halt_after_h", 32'(o_halt), 32'd1);
        applyStimulus(8'h72);
        @(negedge i_clk);
        checkOutput("halt_after_r", 32'(o_halt), 32'd0);

        $display("[TB] single step");
        applyStimulus(8'h68);
        applyStimulus(8'h73);
        @(negedge i_clk);
        checkOutput("step_release_halt", 32'(o_halt), 32'd0);
        checkOutput("step_cmd_ready", 32'(o_cmd_ready), 32'd0);
        @(negedge i_clk);
        checkOutput("step_refreeze_halt", 32'(o_halt), 32'd1);
        checkOutput("step_ready_back", 32'(o_cmd_ready), 32'd1);
        applyStimulus(8'h72);

        $display("[TB] dump, tx always ready");
        ready_mode = 0;
        applyStimulus(8'h64);
        pushDump(accept_cyc + 161);
        @(negedge i_clk);
        checkOutput("dump_wait_halt", 32'(o_halt), 32'd1);
        checkOutput("dump_wait_busy", 32'(o_busy), 32'd1);
        waitDone("dump1_done_seen");
        checkOutput("dump1_busy_after", 32'(o_busy), 32'd0);
        checkOutput("dump1_ready_after", 32'(o_cmd_ready), 32'd1);
        @(negedge i_clk);
        checkOutput("dump1_halt_restored", 32'(o_halt), 32'(m_user | m_prog));

        $display("[TB] dump, tx ready 1-in-3, user halted");
        ready_mode = 1;
        applyStimulus(8'h68);
        applyStimulus(8'h64);
        pushDump(-1);
        waitDone("dump2_done_seen");
        @(negedge i_clk);
        checkOutput("dump2_halt_restored", 32'(o_halt), 32'(m_user | m_prog));
        applyStimulus(8'h72);

        $display("[TB] random command stream");
        for (int k = 0; k < 30; k++) begin
            logic [7:0] c;
            int sel;
            sel = $urandom_range(9);
            if (sel < 4)      c = 8'h68;
            else if (sel < 8) c = 8'h72;
            else begin
                c = 8'($urandom_range(255));
                while (isKnown(c)) c = 8'($urandom_range(255));
            end
            applyStimulus(c);
            @(negedge i_clk);
            checkOutput("rand_halt", 32'(o_halt), 32'(m_user | m_prog));
        end
        applyStimulus(8'h72);

        $display("[TB] program halt is sticky");
        @(posedge i_clk);
        #1;
        i_prog_halt = 1'b1;
        m_prog      = 1'b1;
        @(posedge i_clk);
        #1;
        i_prog_halt = 1'b0;
        @(negedge i_clk);
        checkOutput("prog_halt_set", 32'(o_halt), 32'd1);
        applyStimulus(8'h72);
        @(negedge i_clk);
        checkOutput("prog_halt_after_r", 32'(o_halt), 32'd1);
        applyStimulus(8'h73);
        @(negedge i_clk);
        checkOutput("step_ignored_busy", 32'(o_busy), 32'd0);
        checkOutput("step_ignored_halt", 32'(o_halt), 32'd1);
        applyStimulus(8'h41);
        @(negedge i_clk);
        @(negedge i_clk);

        $display("[TB] dump of random register values");
        for (int r = 0; r < N_REGS; r++) regfile[r] = $urandom;
        applyStimulus(8'h64);
        pushDump(-1);
        waitDone("dump3_done_seen");
        @(negedge i_clk);
        checkOutput("dump3_halt_restored", 32'(o_halt), 32'(m_user | m_prog));

        $display("[TB] reset during 40th byte");
        for (int r = 0; r < N_REGS; r++) regfile[r] = 32'h1111_0000 + 32'(r);
        begin
            int base;
            int n;
            base = bytes_seen;
            applyStimulus(8'h64);
            pushDump(-1);
            n = 0;
            while (!((bytes_seen - base) == 39 && o_tx_valid) && n < 3000) begin
                @(posedge i_clk);
                #1;
                n++;
            end
            checkOutput("reached_byte40", 32'(bytes_seen - base), 32'd39);
        end
        i_reset = 1'b1;
        byte_q.delete();
        done_q.delete();
        m_user = 1'b0;
        m_prog = 1'b0;
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        checkResetValues("midreset");
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        $display("[TB] dump restarts from r0");
        ready_mode = 0;
        applyStimulus(8'h64);
        pushDump(accept_cyc + 161);
        @(negedge i_clk);
        checkOutput("restart_r_addr", 32'(o_r_addr), 32'd0);
        waitDone("dump4_done_seen");
        @(negedge i_clk);
        checkOutput("dump4_halt_restored", 32'(o_halt), 32'd0);

        repeat (3) @(negedge i_clk);
        checkOutput("bytes_left", 32'(byte_q.size()), 32'd0);
        checkOutput("done_left", 32'(done_q.size()), 32'd0);
        checkOutput("err_left", 32'(err_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_sequencer.md
# debug_sequencer

Command-driven controller that owns the pipeline halt line and the register-file debug read port of the instruction-decode stage. It accepts single-byte commands from the debug host link (UART byte layer), freezes or releases the pipeline, single-steps it, and streams all 32 general-purpose registers out as bytes. It sits between the UART receive/transmit byte interfaces and the decode stage's `i_halt` / `i_r_addr` / `o_r_data` pins.

## Interface
- `N_REGS`, 32, number of registers dumped.
- `NB_ADDR`, 5, register address width.
- `NB_DATA`, 32, register data width; must be a multiple of 8.
- `i_clk` in 1: clock. Reset `i_reset`, synchronous, active-high; clock `i_clk`.
- `i_reset` in 1: synchronous active-high reset.
- `i_cmd_valid` in 1: command byte valid.
- `i_cmd` in 8: command byte.
- `o_cmd_ready` out 1: command accepted when `i_cmd_valid & o_cmd_ready`.
- `i_prog_halt` in 1: decode stage decoded the HALT instruction (0xFFFFFFFF).
- `o_halt` out 1: registered pipeline freeze, drives decode `i_halt`.
- `o_r_addr` out NB_ADDR: debug register read address.
- `i_r_data` in NB_DATA: combinational register read data for `o_r_addr`.
- `o_tx_data` out 8: byte to host.
- `o_tx_valid` out 1: byte valid; held with stable data until `i_tx_ready`.
- `i_tx_ready` in 1: transmitter accepts byte.
- `o_busy` out 1: FSM not in IDLE.
- `o_done` out 1: one-cycle pulse, dump complete.
- `o_cmd_err` out 1: one-cycle pulse, unknown command byte.

## Operation
- Commands: 0x68 'h' HALT, 0x72 'r' RUN, 0x73 's' STEP, 0x64 'd' DUMP. Any other byte: accepted, pulses `o_cmd_err` next cycle, no other effect.
- Halt terms: `user_halt` (set by 'h', cleared by 'r'), `prog_halt` (sticky, set when `i_prog_halt`=1, cleared only by reset), `dump_halt` (set during dump). `o_halt` register = OR of the three, except the STEP release cycle.
- 'r' while `prog_halt`=1: `user_halt` clears but `o_halt` stays 1.
- FSM states: IDLE, STEP, DUMP_WAIT, LOAD, SEND.
- IDLE: `o_cmd_ready`=1; only state accepting commands. 'h'/'r' update `user_halt`, stay IDLE. 's' goes to STEP only if `user_halt`=1 and `prog_halt`=0, else no-op. 'd' goes to DUMP_WAIT, sets `dump_halt`, clears register counter.
- STEP: `o_halt`=0 for exactly one cycle, then back to IDLE with `o_halt`=1 (pipeline advances exactly one clock). If `i_prog_halt` rises during STEP, `prog_halt` sets normally.
- DUMP_WAIT: one cycle so registered `o_halt`=1 is seen by decode before reading. Next state LOAD.
- LOAD: capture `i_r_data` into a NB_DATA shift register; byte index = 0. Next SEND.
- SEND: `o_tx_data` = most significant byte of shift register (MSB-first). On `i_tx_ready`: shift left 8, byte index +1. After NB_DATA/8 bytes: if counter = N_REGS−1 go IDLE, clear `dump_halt`, pulse `o_done`; else counter +1, go LOAD.
- `o_r_addr` = register counter at all times.
- Halt state after dump equals halt state before it (`user_halt`, `prog_halt` untouched).

## Timing
- Reset values: `o_halt`=0, `o_r_addr`=0, `o_tx_data`=0, `o_tx_valid`=0, `o_cmd_ready`=1, `o_busy`=0, `o_done`=0, `o_cmd_err`=0; FSM IDLE, all halt terms 0.
- Command accepted at edge N: `o_halt` update visible at N+1; `o_cmd_ready`=0 from N+1 for 's'/'d'.
- DUMP with `i_tx_ready` held 1: accept at edge 0, DUMP_WAIT cycle 1, each register 5 cycles (1 LOAD + 4 SEND), last byte accepted at cycle 161, `o_done`=1 in cycle 162, `o_busy`=0 and `o_cmd_ready`=1 in cycle 162.
- `o_tx_valid` never drops or changes data while `i_tx_ready`=0.
- `i_prog_halt` sampled every cycle in every state.
- Reset mid-dump or mid-step: next cycle all outputs at reset values, no partial byte re-sent.

## Test plan
- Reset, send 'h' -> `o_halt`=1 one cycle after accept; send 'r' -> `o_halt`=0 one cycle after.
- 'h' then 's' -> `o_halt` low exactly one cycle, then 1; `o_cmd_ready` back to 1.
- Preload r0..r31 = 0x11110000+i, 'd' with `i_tx_ready`=1 -> 128 bytes, first 0x11,0x11,0x00,0x00, last 0x11,0x11,0x00,0x1F; `o_done` at cycle 162; `o_halt` returns to 0.
- Dump with `i_tx_ready` toggling 1-in-3 -> identical byte stream, data stable while valid and not ready.
- Pulse `i_prog_halt`, then 'r' -> `o_halt` stays 1; 's' ignored; byte 0x41 -> `o_cmd_err` one-cycle pulse.
- Assert `i_reset` during 40th dump byte -> all outputs at reset values next cycle; new 'd' restarts from r0.
